// File: rtl/exa_crosb_output_arbiter_with_vcs.sv
// exa_crosb_output_arbiter_with_vcs
// Per-output arbiter of the crossbar. Collects one-hot VC requests from every
// input, filters them by destination, picks the highest priority class and
// round-robins among inputs inside that class. The grant is held until the
// winner's last valid beat.
// Optional feature macro: EXA_OUTARB_TIMEOUT_EN (packet watchdog, o_timeout).
module exa_crosb_output_arbiter_with_vcs #(
  parameter int input_num     = 4,
  parameter int output_num    = 4,
  parameter int prio_num      = 2,
  parameter int vc_num        = 2,
  parameter int OUTPUT_ID     = 0,
  parameter int MAX_PKT_BEATS = 64,
  localparam int VC_TOT = prio_num * vc_num,
  localparam int IN_W   = (input_num > 1) ? $clog2(input_num) : 1,
  localparam int DEST_W = (output_num > 1) ? $clog2(output_num) : 1,
  localparam int VC_W   = (VC_TOT > 1) ? $clog2(VC_TOT) : 1,
  localparam int CLS_W  = (prio_num > 1) ? $clog2(prio_num) : 1
) (
  input  logic                                 clk,
  input  logic                                 resetn,
  input  logic [input_num-1:0][VC_TOT-1:0]     i_request,
  input  logic [input_num-1:0][DEST_W-1:0]     i_dest,
  input  logic [input_num-1:0]                 i_valid,
  input  logic [input_num-1:0]                 i_last,
  output logic [input_num-1:0]                 o_grant,
  output logic [IN_W-1:0]                      o_sel_input,
  output logic [VC_W-1:0]                      o_sel_vc,
  output logic                                 o_busy,
  output logic                                 o_timeout
);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_GRANTED = 1'b1
  } state_t;

  state_t                           state_q, state_d;
  logic [input_num-1:0]             grant_q, grant_d;
  logic [IN_W-1:0]                  sel_input_q, sel_input_d;
  logic [VC_W-1:0]                  sel_vc_q, sel_vc_d;
  logic [prio_num-1:0][IN_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic                             timeout_q, timeout_d;

`ifdef EXA_OUTARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_PKT_BEATS) + 1;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
`endif

  // Per-input decode: effective request, VC index and priority class.
  logic [input_num-1:0]             req_eff;
  logic [input_num-1:0][VC_W-1:0]   vc_idx;
  logic [input_num-1:0][CLS_W-1:0]  cls_idx;

  genvar gi;
  generate
    for (gi = 0; gi < input_num; gi++) begin : g_dec
      logic [VC_W-1:0] vc_dec;

      assign req_eff[gi] = (|i_request[gi]) && (i_dest[gi] == DEST_W'(OUTPUT_ID));

      // Highest set bit wins, so a malformed multi-hot request still has a
      // well-defined VC and class.
      always_comb begin
        vc_dec = '0;
        for (int v = 0; v < VC_TOT; v++) begin
          if (i_request[gi][v]) vc_dec = VC_W'(v);
        end
      end

      assign vc_idx[gi]  = vc_dec;
      assign cls_idx[gi] = CLS_W'(int'(vc_dec) / vc_num);
    end
  endgenerate

  // Request matrix split by priority class.
  logic [prio_num-1:0][input_num-1:0] class_req;

  // Build the per-class request vectors.
  always_comb begin
    class_req = '0;
    for (int c = 0; c < prio_num; c++) begin
      for (int n = 0; n < input_num; n++) begin
        class_req[c][n] = req_eff[n] && (int'(cls_idx[n]) == c);
      end
    end
  end

  // Winner selection: highest active class, then first requester at or
  // after that class's round-robin pointer.
  logic                win_found;
  logic [CLS_W-1:0]    win_cls;
  logic [IN_W-1:0]     win_idx;

  // Strict-priority class pick followed by a rotating search.
  always_comb begin
    win_found = |req_eff;
    win_cls   = '0;
    for (int c = 0; c < prio_num; c++) begin
      if (|class_req[c]) win_cls = CLS_W'(c);
    end
    win_idx = '0;
    // Walk offsets from farthest to nearest so the nearest match is kept.
    for (int k = input_num - 1; k >= 0; k--) begin
      int idx;
      idx = int'(rr_ptr_q[win_cls]) + k;
      if (idx >= input_num) idx = idx - input_num;
      if (class_req[win_cls][IN_W'(idx)]) win_idx = IN_W'(idx);
    end
  end

  logic release_pkt;

  // Next-state, grant registers, pointer update and watchdog.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    sel_input_d = sel_input_q;
    sel_vc_d    = sel_vc_q;
    rr_ptr_d    = rr_ptr_q;
    timeout_d   = 1'b0;
    release_pkt = 1'b0;
`ifdef EXA_OUTARB_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d          = ST_GRANTED;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          sel_input_d      = win_idx;
          sel_vc_d         = vc_idx[win_idx];
          rr_ptr_d[win_cls] = (int'(win_idx) == input_num - 1) ? '0 : win_idx + IN_W'(1);
`ifdef EXA_OUTARB_TIMEOUT_EN
          cnt_d            = '0;
`endif
        end
      end
      ST_GRANTED: begin
        // Only the granted input's beat qualifiers matter here.
        release_pkt = i_valid[sel_input_q] & i_last[sel_input_q];
`ifdef EXA_OUTARB_TIMEOUT_EN
        cnt_d = cnt_q + CNT_W'(1);
        if (!release_pkt && (cnt_d == CNT_W'(MAX_PKT_BEATS))) begin
          release_pkt = 1'b1;
          timeout_d   = 1'b1;
        end
`endif
        if (release_pkt) begin
          state_d     = ST_IDLE;
          grant_d     = '0;
          sel_input_d = '0;
          sel_vc_d    = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops the grant without a clock.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      sel_input_q <= '0;
      sel_vc_q    <= '0;
      rr_ptr_q    <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      sel_input_q <= sel_input_d;
      sel_vc_q    <= sel_vc_d;
      rr_ptr_q    <= rr_ptr_d;
      timeout_q   <= timeout_d;
    end
  end

`ifdef EXA_OUTARB_TIMEOUT_EN
  // Beat-cycle watchdog counter for the current packet.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
  assign o_timeout = timeout_q;
`else
  assign o_timeout = 1'b0;
`endif

  assign o_grant     = grant_q;
  assign o_sel_input = sel_input_q;
  assign o_sel_vc    = sel_vc_q;
  assign o_busy      = (state_q == ST_GRANTED);

endmodule

// File: tb/tb_exa_crosb_output_arbiter_with_vcs.sv
// Testbench for exa_crosb_output_arbiter_with_vcs: table-driven cycle vectors
// plus hand-written reset and watchdog sequences.
module tb_exa_crosb_output_arbiter_with_vcs;

`ifdef EXA_OUTARB_TIMEOUT_EN
  localparam int MAXB = 8;
`else
  localparam int MAXB = 64;
`endif

  logic             clk;
  logic             resetn;
  logic [3:0][3:0]  i_request;
  logic [3:0][1:0]  i_dest;
  logic [3:0]       i_valid;
  logic [3:0]       i_last;
  logic [3:0]       o_grant;
  logic [1:0]       o_sel_input;
  logic [1:0]       o_sel_vc;
  logic             o_busy;
  logic             o_timeout;

  int tests_run = 0;
  int tests_failed = 0;

  exa_crosb_output_arbiter_with_vcs #(
    .input_num(4), .output_num(4), .prio_num(2), .vc_num(2),
    .OUTPUT_ID(0), .MAX_PKT_BEATS(MAXB)
  ) dut (
    .clk(clk), .resetn(resetn),
    .i_request(i_request), .i_dest(i_dest),
    .i_valid(i_valid), .i_last(i_last),
    .o_grant(o_grant), .o_sel_input(o_sel_input), .o_sel_vc(o_sel_vc),
    .o_busy(o_busy), .o_timeout(o_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] req;
    logic [7:0]  dest;
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [3:0]  exp_grant;
    logic [1:0]  exp_sel;
    logic [1:0]  exp_vc;
    logic        exp_busy;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(string name, logic [15:0] req, logic [7:0] dest,
                              logic [3:0] valid, logic [3:0] last,
                              logic [3:0] g, logic [1:0] s, logic [1:0] v, logic b);
    vec_t r;
    r.name = name; r.req = req; r.dest = dest; r.valid = valid; r.last = last;
    r.exp_grant = g; r.exp_sel = s; r.exp_vc = v; r.exp_busy = b;
    tbl.push_back(r);
  endfunction

  // Packed view of all outputs: {timeout, busy, vc, sel, grant}.
  function automatic logic [9:0] outs();
    return {o_timeout, o_busy, o_sel_vc, o_sel_input, o_grant};
  endfunction

  task automatic chk(string name, logic [9:0] act, logic [9:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got {to,busy,vc,sel,grant}=%b_%b_%b_%b_%b expected %b_%b_%b_%b_%b",
               name, act[9], act[8], act[7:6], act[5:4], act[3:0],
               exp[9], exp[8], exp[7:6], exp[5:4], exp[3:0]);
    end else begin
      $display("[TB] ok   %s: grant=%b sel=%0d vc=%0d busy=%b to=%b",
               name, act[3:0], act[5:4], act[7:6], act[8], act[9]);
    end
  endtask

  task automatic drive(logic [15:0] req, logic [7:0] dest, logic [3:0] valid, logic [3:0] last);
    i_request = req;
    i_dest    = dest;
    i_valid   = valid;
    i_last    = last;
  endtask

  initial begin
    resetn = 1'b0;
    drive(16'h0, 8'h0, 4'h0, 4'h0);

    // Round-robin: all inputs request VC1 (class 0), single-beat packets.
    add("rr_g0",   16'h2222, 8'h00, 4'hF, 4'hF, 4'b0001, 2'd0, 2'd1, 1'b1);
    add("rr_i0",   16'h2222, 8'h00, 4'hF, 4'hF, 4'b0000, 2'd0, 2'd0, 1'b0);
    add("rr_g1",   16'h2222, 8'h00, 4'hF, 4'hF, 4'b0010, 2'd1, 2'd1, 1'b1);
    add("rr_i1",   16'h2222, 8'h00, 4'hF, 4'hF, 4'b0000, 2'd0, 2'd0, 1'b0);
    add("rr_g2",   16'h2222, 8'h00, 4'hF, 4'hF, 4'b0100, 2'd2, 2'd1, 1'b1);
    add("rr_i2",   16'h2222, 8'h00, 4'hF, 4'hF, 4'b0000, 2'd0, 2'd0, 1'b0);
    add("rr_g3",   16'h2222, 8'h00, 4'hF, 4'hF, 4'b1000, 2'd3, 2'd1, 1'b1);
    add("rr_i3",   16'h2222, 8'h00, 4'hF, 4'hF, 4'b0000, 2'd0, 2'd0, 1'b0);
    add("rr_g0b",  16'h2222, 8'h00, 4'hF, 4'hF, 4'b0001, 2'd0, 2'd1, 1'b1);
    add("rr_i0b",  16'h2222, 8'h00, 4'hF, 4'hF, 4'b0000, 2'd0, 2'd0, 1'b0);
    add("idle_a",  16'h0000, 8'h00, 4'h0, 4'h0, 4'b0000, 2'd0, 2'd0, 1'b0);
    // Basic grant: input 2 VC1, 3-beat packet, then immediate re-request.
    add("basic_g", 16'h0200, 8'h00, 4'h0, 4'h0, 4'b0100, 2'd2, 2'd1, 1'b1);
    add("basic_b1",16'h0000, 8'h00, 4'h4, 4'h0, 4'b0100, 2'd2, 2'd1, 1'b1);
    add("basic_b2",16'h0000, 8'h00, 4'h4, 4'h0, 4'b0100, 2'd2, 2'd1, 1'b1);
    add("basic_lst",16'h0200,8'h00, 4'h4, 4'h4, 4'b0000, 2'd0, 2'd0, 1'b0);
    add("basic_re",16'h0200, 8'h00, 4'h0, 4'h0, 4'b0100, 2'd2, 2'd1, 1'b1);
    add("basic_rl",16'h0000, 8'h00, 4'h4, 4'h4, 4'b0000, 2'd0, 2'd0, 1'b0);
    add("idle_b",  16'h0000, 8'h00, 4'h0, 4'h0, 4'b0000, 2'd0, 2'd0, 1'b0);
    // Priority: input 0 VC0 (class 0) vs input 3 VC2 (class 1).
    add("prio_hi", 16'h4001, 8'h00, 4'h0, 4'h0, 4'b1000, 2'd3, 2'd2, 1'b1);
    add("prio_rl", 16'h4001, 8'h00, 4'h8, 4'h8, 4'b0000, 2'd0, 2'd0, 1'b0);
    add("prio_lo", 16'h0001, 8'h00, 4'h0, 4'h0, 4'b0001, 2'd0, 2'd0, 1'b1);
    add("prio_rl2",16'h0001, 8'h00, 4'h1, 4'h1, 4'b0000, 2'd0, 2'd0, 1'b0);
    add("idle_c",  16'h0000, 8'h00, 4'h0, 4'h0, 4'b0000, 2'd0, 2'd0, 1'b0);
    // Destination filter: input 1 targets output 2.
    add("dest_f1", 16'h0020, 8'h08, 4'h0, 4'h0, 4'b0000, 2'd0, 2'd0, 1'b0);
    add("dest_f2", 16'h0020, 8'h08, 4'h0, 4'h0, 4'b0000, 2'd0, 2'd0, 1'b0);
    // No preemption: input 0 class 0 held while input 2 raises class 1.
    add("np_g0",   16'h0001, 8'h00, 4'h0, 4'h0, 4'b0001, 2'd0, 2'd0, 1'b1);
    add("np_hold1",16'h0800, 8'h00, 4'h5, 4'h4, 4'b0001, 2'd0, 2'd0, 1'b1);
    add("np_lnov", 16'h0800, 8'h00, 4'h4, 4'h5, 4'b0001, 2'd0, 2'd0, 1'b1);
    add("np_rel",  16'h0800, 8'h00, 4'h5, 4'h5, 4'b0000, 2'd0, 2'd0, 1'b0);
    add("np_g2",   16'h0800, 8'h00, 4'h0, 4'h0, 4'b0100, 2'd2, 2'd3, 1'b1);
    add("np_rel2", 16'h0000, 8'h00, 4'h4, 4'h4, 4'b0000, 2'd0, 2'd0, 1'b0);
    add("idle_d",  16'h0000, 8'h00, 4'h0, 4'h0, 4'b0000, 2'd0, 2'd0, 1'b0);

    // Reset state.
    repeat (2) @(posedge clk);
    #1 chk("reset_state", outs(), 10'b0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1 chk("idle_after_reset", outs(), 10'b0);

    // Table-driven vectors: drive on negedge, check 1 time unit after posedge.
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].req, tbl[i].dest, tbl[i].valid, tbl[i].last);
      @(posedge clk);
      #1 chk(tbl[i].name, outs(),
             {1'b0, tbl[i].exp_busy, tbl[i].exp_vc, tbl[i].exp_sel, tbl[i].exp_grant});
    end

    // Reset mid-packet: grant input 1 (pointer moves to 2), then reset.
    @(negedge clk);
    drive(16'h0020, 8'h00, 4'h0, 4'h0);
    @(posedge clk);
    #1 chk("rst_pre_grant", outs(), {1'b0, 1'b1, 2'd1, 2'd1, 4'b0010});
    #1 resetn = 1'b0;
    #1 chk("rst_async_drop", outs(), 10'b0);
    @(negedge clk);
    drive(16'h2020, 8'h00, 4'h0, 4'h0);
    @(posedge clk);
    #1 chk("rst_held", outs(), 10'b0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1 chk("rst_ptr_zero", outs(), {1'b0, 1'b1, 2'd1, 2'd1, 4'b0010});
    @(negedge clk);
    drive(16'h0000, 8'h00, 4'h2, 4'h2);
    @(posedge clk);
    #1 chk("rst_release", outs(), 10'b0);

    // Packet with no last beat: input 1 granted, input 2 pending behind it.
    @(negedge clk);
    drive(16'h0020, 8'h00, 4'h0, 4'h0);
    @(posedge clk);
    #1 chk("wd_grant1", outs(), {1'b0, 1'b1, 2'd1, 2'd1, 4'b0010});
    @(negedge clk);
    drive(16'h0220, 8'h00, 4'h2, 4'h0);
`ifdef EXA_OUTARB_TIMEOUT_EN
    for (int c = 1; c < MAXB; c++) begin
      @(posedge clk);
      #1 chk($sformatf("wd_hold%0d", c), outs(), {1'b0, 1'b1, 2'd1, 2'd1, 4'b0010});
    end
    @(posedge clk);
    #1 chk("wd_timeout", outs(), {1'b1, 1'b0, 2'd0, 2'd0, 4'b0000});
    @(posedge clk);
    #1 chk("wd_next_g2", outs(), {1'b0, 1'b1, 2'd1, 2'd2, 4'b0100});
`else
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1 chk($sformatf("hold_forever%0d", c), outs(), {1'b0, 1'b1, 2'd1, 2'd1, 4'b0010});
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
